// File: rtl/user_param_cache_if.sv
// -----------------------------------------------------------------------------
// user_param_cache_if
// Purpose : bundles the request/response signals of user_param_cache so the
//           cache and its user connect through one port.
// Signals :
//   i_wr_en / i_wr_idx / i_wr_data : write strobe, entry index, write data
//   i_rd_en / i_rd_idx             : read strobe, entry index
//   i_clr_start                    : start a clear-all sweep
//   o_rd_data / o_rd_vld / o_rd_hit: registered read response
//   o_err                          : one-cycle error pulse
//   o_busy                         : clear sweep in progress
// Modports: master (user side, drives i_*), slave (cache side, drives o_*).
// -----------------------------------------------------------------------------
interface user_param_cache_if #(
    parameter int DATA_W = 20,
    parameter int IDX_W  = 6
) ();
    logic              i_wr_en;
    logic [IDX_W-1:0]  i_wr_idx;
    logic [DATA_W-1:0] i_wr_data;
    logic              i_rd_en;
    logic [IDX_W-1:0]  i_rd_idx;
    logic              i_clr_start;
    logic [DATA_W-1:0] o_rd_data;
    logic              o_rd_vld;
    logic              o_rd_hit;
    logic              o_err;
    logic              o_busy;

    modport master (
        output i_wr_en, i_wr_idx, i_wr_data, i_rd_en, i_rd_idx, i_clr_start,
        input  o_rd_data, o_rd_vld, o_rd_hit, o_err, o_busy
    );

    modport slave (
        input  i_wr_en, i_wr_idx, i_wr_data, i_rd_en, i_rd_idx, i_clr_start,
        output o_rd_data, o_rd_vld, o_rd_hit, o_err, o_busy
    );
endinterface

// File: rtl/user_param_cache.sv
// -----------------------------------------------------------------------------
// user_param_cache
// Purpose : NUM_USERS-entry parameter store, each entry DATA_W data bits plus a
//           valid bit. Writes either overwrite or saturating-accumulate
//           (WR_MODE). Reads return a registered response one cycle later with
//           write-first forwarding. A clear-all sweep wipes one entry per cycle
//           while o_busy is high.
// Ports   :
//   i_core_clk : single clock, rising edge
//   i_rx_rst   : synchronous active-high reset
//   io_bus     : user_param_cache_if slave modport (see interface header)
// -----------------------------------------------------------------------------
module user_param_cache #(
    parameter int DATA_W    = 20,
    parameter int NUM_USERS = 40,
    parameter int IDX_W     = 6,
    parameter int WR_MODE   = 0
) (
    input  logic               i_core_clk,
    input  logic               i_rx_rst,
    user_param_cache_if.slave  io_bus
);

    // Index bound widened by one bit so NUM_USERS == 2^IDX_W still compares correctly.
    localparam logic [IDX_W:0]   LP_NUM_USERS = (IDX_W+1)'(NUM_USERS);
    localparam logic [IDX_W-1:0] LP_LAST_IDX  = IDX_W'(NUM_USERS - 1);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    // Saturating add: any carry out clamps to all ones.
    function automatic logic [DATA_W-1:0] sat_add(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        logic [DATA_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum[DATA_W]) begin
            sat_add = {DATA_W{1'b1}};
        end else begin
            sat_add = sum[DATA_W-1:0];
        end
    endfunction

    // Storage and state
    logic [DATA_W-1:0]    r_mem [NUM_USERS];
    logic [NUM_USERS-1:0] r_vld;
    state_t               r_state;
    logic [IDX_W-1:0]     r_cnt;
    logic [DATA_W-1:0]    r_rd_data;
    logic                 r_rd_vld;
    logic                 r_rd_hit;
    logic                 r_err;

    // Combinational helpers
    state_t               w_state_nxt;
    logic                 w_busy;
    logic                 w_sweep_en;
    logic                 w_wr_in_range;
    logic                 w_rd_in_range;
    logic                 w_wr_acc;
    logic [IDX_W-1:0]     w_wr_ptr;
    logic [IDX_W-1:0]     w_rd_ptr;
    logic [DATA_W-1:0]    w_wr_new;

    assign w_wr_in_range = ({1'b0, io_bus.i_wr_idx} < LP_NUM_USERS);
    assign w_rd_in_range = ({1'b0, io_bus.i_rd_idx} < LP_NUM_USERS);
    assign w_wr_acc      = io_bus.i_wr_en & w_wr_in_range & ~w_busy;

    // Clamp pointers so array lookups never leave the storage range.
    assign w_wr_ptr = w_wr_in_range ? io_bus.i_wr_idx : {IDX_W{1'b0}};
    assign w_rd_ptr = w_rd_in_range ? io_bus.i_rd_idx : {IDX_W{1'b0}};

    // Value an accepted write will store; also forwarded to a same-cycle read.
    always_comb begin
        w_wr_new = io_bus.i_wr_data;
        if ((WR_MODE != 0) && r_vld[w_wr_ptr]) begin
            w_wr_new = sat_add(r_mem[w_wr_ptr], io_bus.i_wr_data);
        end else begin
            w_wr_new = io_bus.i_wr_data;
        end
    end

    // Clear FSM state register and sweep counter.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_state <= S_IDLE;
            r_cnt   <= {IDX_W{1'b0}};
        end else begin
            r_state <= w_state_nxt;
            if (w_sweep_en && (r_cnt != LP_LAST_IDX)) begin
                r_cnt <= r_cnt + {{(IDX_W-1){1'b0}}, 1'b1};
            end else begin
                r_cnt <= {IDX_W{1'b0}};
            end
        end
    end

    // Clear FSM next-state logic; a start request while sweeping is ignored.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (io_bus.i_clr_start) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_CLEAR: begin
                if (r_cnt == LP_LAST_IDX) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_CLEAR;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Clear FSM outputs.
    always_comb begin
        w_busy     = 1'b0;
        w_sweep_en = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_busy     = 1'b0;
                w_sweep_en = 1'b0;
            end
            S_CLEAR: begin
                w_busy     = 1'b1;
                w_sweep_en = 1'b1;
            end
            default: begin
                w_busy     = 1'b0;
                w_sweep_en = 1'b0;
            end
        endcase
    end

    // Entry storage: sweep clears and user writes are mutually exclusive
    // because writes are only accepted when not busy.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                r_mem[i] <= {DATA_W{1'b0}};
            end
            r_vld <= {NUM_USERS{1'b0}};
        end else if (w_sweep_en) begin
            r_mem[r_cnt] <= {DATA_W{1'b0}};
            r_vld[r_cnt] <= 1'b0;
        end else if (w_wr_acc) begin
            r_mem[w_wr_ptr] <= w_wr_new;
            r_vld[w_wr_ptr] <= 1'b1;
        end
    end

    // Registered read response; data and hit hold while no read is issued.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_rd_data <= {DATA_W{1'b0}};
            r_rd_vld  <= 1'b0;
            r_rd_hit  <= 1'b0;
        end else if (io_bus.i_rd_en) begin
            r_rd_vld <= 1'b1;
            if (w_busy || !w_rd_in_range) begin
                r_rd_data <= {DATA_W{1'b0}};
                r_rd_hit  <= 1'b0;
            end else if (w_wr_acc && (w_wr_ptr == w_rd_ptr)) begin
                r_rd_data <= w_wr_new;
                r_rd_hit  <= 1'b1;
            end else if (r_vld[w_rd_ptr]) begin
                r_rd_data <= r_mem[w_rd_ptr];
                r_rd_hit  <= 1'b1;
            end else begin
                r_rd_data <= {DATA_W{1'b0}};
                r_rd_hit  <= 1'b0;
            end
        end else begin
            r_rd_vld <= 1'b0;
        end
    end

    // Error pulse: all causes OR together into one pulse.
    always_ff @(posedge i_core_clk) begin
        if (i_rx_rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= (io_bus.i_wr_en & (~w_wr_in_range | w_busy)) |
                     (io_bus.i_rd_en & ~w_rd_in_range);
        end
    end

    assign io_bus.o_rd_data = r_rd_data;
    assign io_bus.o_rd_vld  = r_rd_vld;
    assign io_bus.o_rd_hit  = r_rd_hit;
    assign io_bus.o_err     = r_err;
    assign io_bus.o_busy    = w_busy;

endmodule

// File: tb/tb_user_param_cache.sv
// -----------------------------------------------------------------------------
// tb_user_param_cache
// Purpose : directed self-checking bench. Two caches (overwrite and saturating
//           accumulate) receive identical stimulus; each scenario task checks
//           both against hand-computed values.
// -----------------------------------------------------------------------------
module tb_user_param_cache;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    user_param_cache_if #(.DATA_W(20), .IDX_W(6)) if_ow  ();
    user_param_cache_if #(.DATA_W(20), .IDX_W(6)) if_acc ();

    user_param_cache #(.DATA_W(20), .NUM_USERS(40), .IDX_W(6), .WR_MODE(0)) u_ow (
        .i_core_clk (clk),
        .i_rx_rst   (rst),
        .io_bus     (if_ow)
    );

    user_param_cache #(.DATA_W(20), .NUM_USERS(40), .IDX_W(6), .WR_MODE(1)) u_acc (
        .i_core_clk (clk),
        .i_rx_rst   (rst),
        .io_bus     (if_acc)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drv_idle;
        if_ow.i_wr_en   = 1'b0; if_acc.i_wr_en   = 1'b0;
        if_ow.i_wr_idx  = 6'd0; if_acc.i_wr_idx  = 6'd0;
        if_ow.i_wr_data = 20'h0; if_acc.i_wr_data = 20'h0;
        if_ow.i_rd_en   = 1'b0; if_acc.i_rd_en   = 1'b0;
        if_ow.i_rd_idx  = 6'd0; if_acc.i_rd_idx  = 6'd0;
        if_ow.i_clr_start = 1'b0; if_acc.i_clr_start = 1'b0;
    endtask

    task automatic drv_wr(input logic [5:0] idx, input logic [19:0] data);
        if_ow.i_wr_en   = 1'b1; if_acc.i_wr_en   = 1'b1;
        if_ow.i_wr_idx  = idx;  if_acc.i_wr_idx  = idx;
        if_ow.i_wr_data = data; if_acc.i_wr_data = data;
    endtask

    task automatic drv_rd(input logic [5:0] idx);
        if_ow.i_rd_en  = 1'b1; if_acc.i_rd_en  = 1'b1;
        if_ow.i_rd_idx = idx;  if_acc.i_rd_idx = idx;
    endtask

    task automatic drv_clr;
        if_ow.i_clr_start = 1'b1; if_acc.i_clr_start = 1'b1;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        drv_idle();
        step();
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_err, if_ow.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL ow_reset_flags: got %b expected 0000",
                     {if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_err, if_ow.o_busy});
        end
        n_checks++;
        if ({if_acc.o_rd_vld, if_acc.o_rd_hit, if_acc.o_err, if_acc.o_busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL acc_reset_flags: got %b expected 0000",
                     {if_acc.o_rd_vld, if_acc.o_rd_hit, if_acc.o_err, if_acc.o_busy});
        end
        n_checks++;
        if (if_ow.o_rd_data !== 20'h0) begin
            n_fail++;
            $display("FAIL ow_reset_data: got %h expected 00000", if_ow.o_rd_data);
        end
        rst = 1'b0;
        drv_rd(6'd5);
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL ow_rd5_after_reset: got vld=%b hit=%b data=%h expected 1 0 00000",
                     if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        n_checks++;
        if ({if_acc.o_rd_vld, if_acc.o_rd_hit, if_acc.o_rd_data} !== {1'b1, 1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL acc_rd5_after_reset: got vld=%b hit=%b data=%h expected 1 0 00000",
                     if_acc.o_rd_vld, if_acc.o_rd_hit, if_acc.o_rd_data);
        end
        drv_idle();
        step();
        n_checks++;
        if (if_ow.o_rd_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL ow_vld_single_pulse: got %b expected 0", if_ow.o_rd_vld);
        end
    endtask

    task automatic test_overwrite;
        drv_idle();
        drv_wr(6'd39, 20'hABCDE);
        step();
        drv_idle();
        drv_rd(6'd39);
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 1'b1, 20'hABCDE}) begin
            n_fail++;
            $display("FAIL ow_rd39: got vld=%b hit=%b data=%h expected 1 1 abcde",
                     if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        n_checks++;
        if ({if_acc.o_rd_hit, if_acc.o_rd_data} !== {1'b1, 20'hABCDE}) begin
            n_fail++;
            $display("FAIL acc_rd39_first_write: got hit=%b data=%h expected 1 abcde",
                     if_acc.o_rd_hit, if_acc.o_rd_data);
        end
        drv_idle();
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b0, 1'b1, 20'hABCDE}) begin
            n_fail++;
            $display("FAIL ow_rd_hold: got vld=%b hit=%b data=%h expected 0 1 abcde",
                     if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data);
        end
    endtask

    task automatic test_accumulate;
        drv_idle();
        drv_wr(6'd3, 20'hFFFF0);
        step();
        drv_wr(6'd3, 20'h00020);
        step();
        drv_idle();
        drv_rd(6'd3);
        step();
        n_checks++;
        if ({if_acc.o_rd_hit, if_acc.o_rd_data} !== {1'b1, 20'hFFFFF}) begin
            n_fail++;
            $display("FAIL acc_saturate: got hit=%b data=%h expected 1 fffff",
                     if_acc.o_rd_hit, if_acc.o_rd_data);
        end
        n_checks++;
        if ({if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 20'h00020}) begin
            n_fail++;
            $display("FAIL ow_second_write: got hit=%b data=%h expected 1 00020",
                     if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        drv_idle();
        drv_wr(6'd4, 20'h00010);
        step();
        drv_wr(6'd4, 20'h00005);
        step();
        drv_idle();
        drv_rd(6'd4);
        step();
        n_checks++;
        if (if_acc.o_rd_data !== 20'h00015) begin
            n_fail++;
            $display("FAIL acc_sum: got %h expected 00015", if_acc.o_rd_data);
        end
        n_checks++;
        if (if_ow.o_rd_data !== 20'h00005) begin
            n_fail++;
            $display("FAIL ow_overwrite: got %h expected 00005", if_ow.o_rd_data);
        end
    endtask

    task automatic test_write_first;
        drv_idle();
        drv_wr(6'd7, 20'h12345);
        drv_rd(6'd7);
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 1'b1, 20'h12345}) begin
            n_fail++;
            $display("FAIL ow_write_first: got vld=%b hit=%b data=%h expected 1 1 12345",
                     if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        n_checks++;
        if ({if_acc.o_rd_hit, if_acc.o_rd_data} !== {1'b1, 20'h12345}) begin
            n_fail++;
            $display("FAIL acc_write_first: got hit=%b data=%h expected 1 12345",
                     if_acc.o_rd_hit, if_acc.o_rd_data);
        end
        drv_wr(6'd7, 20'h00001);
        drv_rd(6'd7);
        step();
        n_checks++;
        if (if_acc.o_rd_data !== 20'h12346) begin
            n_fail++;
            $display("FAIL acc_write_first_sum: got %h expected 12346", if_acc.o_rd_data);
        end
        n_checks++;
        if (if_ow.o_rd_data !== 20'h00001) begin
            n_fail++;
            $display("FAIL ow_write_first_b2b: got %h expected 00001", if_ow.o_rd_data);
        end
    endtask

    task automatic test_errors;
        drv_idle();
        drv_wr(6'd40, 20'h00001);
        step();
        n_checks++;
        if ({if_ow.o_err, if_acc.o_err} !== 2'b11) begin
            n_fail++;
            $display("FAIL err_wr_oob: got %b expected 11", {if_ow.o_err, if_acc.o_err});
        end
        drv_idle();
        drv_rd(6'd39);
        step();
        n_checks++;
        if (if_ow.o_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_single_pulse: got %b expected 0", if_ow.o_err);
        end
        n_checks++;
        if ({if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 20'hABCDE}) begin
            n_fail++;
            $display("FAIL ow_oob_no_change: got hit=%b data=%h expected 1 abcde",
                     if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        drv_idle();
        drv_rd(6'd63);
        step();
        n_checks++;
        if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data, if_ow.o_err} !==
            {1'b1, 1'b0, 20'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL ow_rd63: got vld=%b hit=%b data=%h err=%b expected 1 0 00000 1",
                     if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data, if_ow.o_err);
        end
        drv_idle();
        drv_wr(6'd40, 20'h00002);
        drv_rd(6'd63);
        step();
        n_checks++;
        if (if_acc.o_err !== 1'b1) begin
            n_fail++;
            $display("FAIL acc_err_multi_cause: got %b expected 1", if_acc.o_err);
        end
        drv_idle();
        step();
        n_checks++;
        if ({if_ow.o_err, if_acc.o_err} !== 2'b00) begin
            n_fail++;
            $display("FAIL err_multi_single_pulse: got %b expected 00",
                     {if_ow.o_err, if_acc.o_err});
        end
    endtask

    task automatic test_clear;
        int busy_ow;
        int busy_acc;
        busy_ow  = 0;
        busy_acc = 0;
        for (int i = 0; i < 40; i++) begin
            drv_idle();
            drv_wr(6'(i), 20'(i + 1));
            step();
        end
        drv_idle();
        drv_rd(6'd20);
        step();
        n_checks++;
        if ({if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 20'd21}) begin
            n_fail++;
            $display("FAIL ow_fill_rd20: got hit=%b data=%h expected 1 00015",
                     if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        drv_idle();
        drv_clr();
        drv_wr(6'd0, 20'h00777);
        step();
        n_checks++;
        if ({if_ow.o_busy, if_ow.o_err} !== 2'b10) begin
            n_fail++;
            $display("FAIL clr_start_busy_err: got %b expected 10", {if_ow.o_busy, if_ow.o_err});
        end
        for (int c = 0; c < 100; c++) begin
            if (!if_ow.o_busy) break;
            busy_ow++;
            busy_acc += int'(if_acc.o_busy);
            drv_idle();
            if (busy_ow == 10) begin
                drv_wr(6'd5, 20'h99999);
                drv_clr();
            end
            if (busy_ow == 20) begin
                drv_rd(6'd20);
            end
            step();
            if (busy_ow == 10) begin
                n_checks++;
                if ({if_ow.o_err, if_acc.o_err} !== 2'b11) begin
                    n_fail++;
                    $display("FAIL err_wr_busy: got %b expected 11", {if_ow.o_err, if_acc.o_err});
                end
            end
            if (busy_ow == 20) begin
                n_checks++;
                if ({if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b1, 1'b0, 20'h0}) begin
                    n_fail++;
                    $display("FAIL ow_rd_busy: got vld=%b hit=%b data=%h expected 1 0 00000",
                             if_ow.o_rd_vld, if_ow.o_rd_hit, if_ow.o_rd_data);
                end
            end
        end
        n_checks++;
        if (busy_ow != 40) begin
            n_fail++;
            $display("FAIL ow_busy_len: got %0d expected 40", busy_ow);
        end
        n_checks++;
        if (busy_acc != 40 || if_acc.o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL acc_busy_len: got %0d busy=%b expected 40 0", busy_acc, if_acc.o_busy);
        end
        for (int i = 0; i < 40; i++) begin
            drv_idle();
            drv_rd(6'(i));
            step();
            n_checks++;
            if ({if_ow.o_rd_hit, if_ow.o_rd_data, if_acc.o_rd_hit, if_acc.o_rd_data} !==
                {1'b0, 20'h0, 1'b0, 20'h0}) begin
                n_fail++;
                $display("FAIL post_clear_rd idx=%0d: got ow %b/%h acc %b/%h expected 0/00000",
                         i, if_ow.o_rd_hit, if_ow.o_rd_data, if_acc.o_rd_hit, if_acc.o_rd_data);
            end
        end
    endtask

    task automatic test_reset_mid_sweep;
        drv_idle();
        drv_wr(6'd30, 20'h00055);
        step();
        drv_idle();
        drv_clr();
        step();
        drv_idle();
        repeat (5) step();
        n_checks++;
        if (if_ow.o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ow_busy_before_reset: got %b expected 1", if_ow.o_busy);
        end
        rst = 1'b1;
        step();
        n_checks++;
        if ({if_ow.o_busy, if_acc.o_busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL busy_after_reset: got %b expected 00", {if_ow.o_busy, if_acc.o_busy});
        end
        rst = 1'b0;
        drv_wr(6'd1, 20'h000AA);
        step();
        drv_idle();
        drv_rd(6'd1);
        step();
        n_checks++;
        if ({if_ow.o_busy, if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b0, 1'b1, 20'h000AA}) begin
            n_fail++;
            $display("FAIL ow_first_edge_after_reset: got busy=%b hit=%b data=%h expected 0 1 000aa",
                     if_ow.o_busy, if_ow.o_rd_hit, if_ow.o_rd_data);
        end
        n_checks++;
        if ({if_acc.o_rd_hit, if_acc.o_rd_data} !== {1'b1, 20'h000AA}) begin
            n_fail++;
            $display("FAIL acc_first_edge_after_reset: got hit=%b data=%h expected 1 000aa",
                     if_acc.o_rd_hit, if_acc.o_rd_data);
        end
        drv_idle();
        drv_rd(6'd30);
        step();
        n_checks++;
        if ({if_ow.o_rd_hit, if_ow.o_rd_data} !== {1'b0, 20'h0}) begin
            n_fail++;
            $display("FAIL ow_reset_cleared_entry30: got hit=%b data=%h expected 0 00000",
                     if_ow.o_rd_hit, if_ow.o_rd_data);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        drv_idle();
        test_reset();
        test_overwrite();
        test_accumulate();
        test_write_first();
        test_errors();
        test_clear();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
